// File: rtl/simon_round_ctrl.sv
// SIMON32/64 round sequencer.
// Steps the external round/key-schedule datapath through one block:
// a load pulse, ROUNDS round enables with the matching z constant bit,
// then a held result-valid until the host acknowledges. It also counts
// acknowledged blocks. All outputs are registered copies of the decoded
// next state, so nothing combinational runs from an input to an output.
module simon_round_ctrl #(
    parameter int                ROUNDS = 32,
    parameter int                Z_LEN  = 62,
    parameter logic [Z_LEN-1:0]  Z_SEQ  = 62'b11111010001001010110000111001101111101000100101011000011100110,
    parameter int                CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             res_ack,
    output logic             busy,
    output logic             dp_load,
    output logic             dp_round_en,
    output logic [5:0]       round_idx,
    output logic             z_bit,
    output logic             res_valid,
    output logic [CNT_W-1:0] blocks_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Index of the last round and of z_0 inside the MSB-first constant.
    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);
    localparam logic [5:0] Z_TOP      = 6'(Z_LEN - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [5:0]       r_cnt;
    logic [5:0]       w_cnt_next;
    logic [CNT_W-1:0] r_blocks;
    logic [CNT_W-1:0] w_blocks_next;
    logic [5:0]       w_z_index;
    logic             w_z_next;

    logic             r_busy;
    logic             r_dp_load;
    logic             r_round_en;
    logic [5:0]       r_round_idx;
    logic             r_z_bit;
    logic             r_res_valid;

    // z_j for the round that will be active next cycle (constant is MSB first).
    assign w_z_index = Z_TOP - w_cnt_next;
    assign w_z_next  = Z_SEQ[w_z_index];

    // Next-state, round counter and block counter; abort overrides everything.
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_blocks_next = r_blocks;
        if (abort) begin
            w_state_next = S_IDLE;
            w_cnt_next   = 6'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_cnt_next = 6'd0;
                    if (start) begin
                        w_state_next = S_LOAD;
                    end
                end
                S_LOAD: begin
                    w_state_next = S_RUN;
                    w_cnt_next   = 6'd0;
                end
                S_RUN: begin
                    if (r_cnt == LAST_ROUND) begin
                        w_state_next = S_DONE;
                        w_cnt_next   = 6'd0;
                    end else begin
                        w_cnt_next = r_cnt + 6'd1;
                    end
                end
                S_DONE: begin
                    // start is deliberately not looked at here; only ack leaves DONE.
                    if (res_ack) begin
                        w_state_next  = S_IDLE;
                        w_blocks_next = r_blocks + 1'b1;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = 6'd0;
                end
            endcase
        end
    end

    // State, counters and registered Moore outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 6'd0;
            r_blocks    <= '0;
            r_busy      <= 1'b0;
            r_dp_load   <= 1'b0;
            r_round_en  <= 1'b0;
            r_round_idx <= 6'd0;
            r_z_bit     <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_blocks    <= w_blocks_next;
            r_busy      <= (w_state_next != S_IDLE);
            r_dp_load   <= (w_state_next == S_LOAD);
            r_round_en  <= (w_state_next == S_RUN);
            r_round_idx <= (w_state_next == S_RUN) ? w_cnt_next : 6'd0;
            r_z_bit     <= (w_state_next == S_RUN) ? w_z_next : 1'b0;
            r_res_valid <= (w_state_next == S_DONE);
        end
    end

    assign busy        = r_busy;
    assign dp_load     = r_dp_load;
    assign dp_round_en = r_round_en;
    assign round_idx   = r_round_idx;
    assign z_bit       = r_z_bit;
    assign res_valid   = r_res_valid;
    assign blocks_done = r_blocks;

endmodule

// File: doc/simon_round_ctrl.md
Name: simon_round_ctrl

Overview:
Sequencer for the SIMON32/64 encryption round datapath behind the SPI front end. It accepts a start request, pulses a one-cycle load, and drives one round-enable per cycle for ROUNDS cycles. It supplies the round index and the key-schedule constant bit z_j, then holds result-valid until the host acknowledges. The round and key-schedule registers live in the datapath; this block owns only sequencing, the handshake and the block counter.

Parameters:
ROUNDS, 32, number of rounds per block (legal range 2..62).
Z_LEN, 62, length of the z constant sequence.
Z_SEQ, 62'b11111010001001010110000111001101111101000100101011000011100110, z0 sequence, MSB first; z_j = Z_SEQ[Z_LEN-1-j].
CNT_W, 8, width of the completed-block counter.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request encryption of the block/key presented to the datapath
abort  input  1  cancel the current operation; priority over start
res_ack  input  1  host has read the ciphertext
busy  output  1  high in LOAD, RUN and DONE states
dp_load  output  1  one-cycle pulse: datapath captures plaintext and key words
dp_round_en  output  1  datapath performs one round plus one key-schedule step
round_idx  output  6  current round number j (0..ROUNDS-1), 0 when not in RUN
z_bit  output  1  z_j for current round_idx, 0 when not in RUN
res_valid  output  1  ciphertext in datapath is final; held until res_ack
blocks_done  output  CNT_W  count of completed (acknowledged) blocks, wraps

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, round counter=0, blocks_done=0. All outputs are 0.
- Outputs are Moore outputs (decoded from registered state/counter); no combinational path from inputs to outputs.
- States: IDLE, LOAD, RUN, DONE.
- IDLE: start=1 & abort=0 -> LOAD.
- LOAD: dp_load=1 for exactly this cycle; round counter cleared to 0; -> RUN.
- RUN:
  - dp_round_en=1, round_idx=counter, z_bit=Z_SEQ[Z_LEN-1-counter].
  - counter increments each cycle.
  - When counter==ROUNDS-1: -> DONE and counter returns to 0.
- DONE:
  - res_valid=1.
  - res_ack=1 -> IDLE and blocks_done increments by 1, wrapping modulo 2^CNT_W.
  - start is ignored in DONE.
- Latency: with start sampled at edge 0, LOAD is the cycle after edge 0 and RUN covers the next ROUNDS cycles. res_valid first rises ROUNDS+2 cycles after the start edge (34 for the defaults), and exactly ROUNDS dp_round_en cycles have elapsed.
- start held high: one block runs per IDLE visit. After res_ack the block returns to IDLE for one cycle, then restarts if start is still high.
- abort=1 in any state:
  - next state is IDLE and the counter clears; blocks_done is unchanged.
  - An abort in the same cycle as res_ack in DONE counts as abort, so no increment.
  - An abort in the same cycle as the final RUN round goes to IDLE, not DONE.
- res_ack outside DONE is ignored.
- Width rule: round_idx is zero-extended from the counter; indices ≥ Z_LEN never occur because ROUNDS ≤ Z_LEN.
- Asynchronous reset mid-RUN forces IDLE immediately. The datapath contents are then undefined, and the next start reloads them.

Test Plan:
- Reset mid-RUN (round_idx=10): assert rst_n low -> all outputs 0 without a clock edge; after release, blocks_done=0 and state is IDLE.
- Single start pulse -> dp_load high for 1 cycle at cycle 1, then exactly 32 dp_round_en cycles with round_idx 0..31. z_bit sequence for j=0..9 is 1,1,1,1,1,0,1,0,0,0. res_valid rises at cycle 34 and holds for 5 cycles with no ack; ack -> IDLE, blocks_done=1.
- Known-answer test with the bench datapath model: key 1918 1110 0908 0100, plaintext 6565 6877 -> ciphertext c69b e9bb while res_valid=1.
- abort asserted at round_idx=15 -> next cycle IDLE, dp_round_en=0, blocks_done unchanged. A following start completes normally with round_idx restarting at 0.
- start held high across res_ack for 3 blocks -> one IDLE cycle between blocks, blocks_done=3; start pulses during RUN and DONE are ignored (no extra dp_load).
- CNT_W=2 and 5 acknowledged blocks -> blocks_done sequence 1,2,3,0,1. abort and res_ack in the same DONE cycle -> no increment.
